// File: rtl/add_arb.sv
// add_arb: round-robin arbiter that shares one registered adder among N_REQ
// requesters. Accepted operand pairs are registered onto add_a/add_b, and a
// tag pipeline of ADD_LAT+1 stages carries the requester id alongside the
// adder latency so each sum is routed back as a one-cycle rsp_valid pulse.
//
// Build option: define ADD_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// always wins, no rotating pointer). Left undefined, the arbiter is
// round-robin.
module add_arb #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int ADD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_s,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_s,
    output logic                     busy
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int N_STG = ADD_LAT + 1;

    // ------------------------------------------------------------------
    // Search start pointer
    // ------------------------------------------------------------------
    logic [ID_W-1:0] ptr_cur;
    logic            xfer;
    logic [ID_W-1:0] gnt_id;

`ifdef ADD_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign ptr_cur = '0;
`else
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    // Pointer moves just past the granted requester; holds otherwise.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (gnt_id == ID_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + ID_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_cur = ptr_q;
`endif

    // ------------------------------------------------------------------
    // Grant: rotate the request vector so the pointer sits at bit 0, pick
    // the lowest set bit, and rotate the one-hot result back. Shift amounts
    // of N_REQ produce zero, so ptr_cur == 0 degenerates cleanly.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] rot_valid;
    logic [N_REQ-1:0] rot_first;
    logic [N_REQ-1:0] gnt_raw;

    assign rot_valid = (req_valid >> ptr_cur) |
                       (req_valid << (N_REQ - int'(ptr_cur)));

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign rot_first[gi] = rot_valid[gi];
            end else begin : g_upper
                assign rot_first[gi] = rot_valid[gi] & ~(|rot_valid[gi-1:0]);
            end
        end
    endgenerate

    assign gnt_raw   = (rot_first << ptr_cur) |
                       (rot_first >> (N_REQ - int'(ptr_cur)));
    assign req_ready = (en && !rst) ? gnt_raw : '0;
    assign xfer      = |req_ready;

    // ------------------------------------------------------------------
    // One-hot grant to id and operand select, built as OR chains since the
    // grant vector has at most one bit set.
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  id_chain [0:N_REQ];
    logic [WIDTH-1:0] a_chain  [0:N_REQ];
    logic [WIDTH-1:0] b_chain  [0:N_REQ];

    assign id_chain[0] = '0;
    assign a_chain[0]  = '0;
    assign b_chain[0]  = '0;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
            assign id_chain[gi+1] = id_chain[gi] |
                                    (req_ready[gi] ? ID_W'(gi) : '0);
            assign a_chain[gi+1]  = a_chain[gi] |
                                    (req_ready[gi] ? req_a[gi*WIDTH +: WIDTH] : '0);
            assign b_chain[gi+1]  = b_chain[gi] |
                                    (req_ready[gi] ? req_b[gi*WIDTH +: WIDTH] : '0);
        end
    endgenerate

    assign gnt_id = id_chain[N_REQ];

    // ------------------------------------------------------------------
    // Adder operand registers: load on a transfer, hold otherwise.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_a_d;
    logic [WIDTH-1:0] add_b_q;
    logic [WIDTH-1:0] add_b_d;

    // Next operand values.
    always_comb begin
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        if (xfer) begin
            add_a_d = a_chain[N_REQ];
            add_b_d = b_chain[N_REQ];
        end
    end

    // Operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
        end
    end

    assign add_a = add_a_q;
    assign add_b = add_b_q;

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 captures the transfer, later stages shift
    // unconditionally so responses keep their schedule even with en low.
    // ------------------------------------------------------------------
    logic [N_STG-1:0] tag_vld_q;
    logic [N_STG-1:0] tag_vld_d;
    logic [ID_W-1:0]  tag_id_q [0:N_STG-1];
    logic [ID_W-1:0]  tag_id_d [0:N_STG-1];

    assign tag_vld_d[0] = xfer;
    assign tag_id_d[0]  = gnt_id;

    generate
        for (genvar gi = 1; gi < N_STG; gi++) begin : g_shift
            assign tag_vld_d[gi] = tag_vld_q[gi-1];
            assign tag_id_d[gi]  = tag_id_q[gi-1];
        end

        for (genvar gi = 0; gi < N_STG; gi++) begin : g_stage
            // Tag stage register; reset discards everything in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_vld_q[gi] <= 1'b0;
                    tag_id_q[gi]  <= '0;
                end else begin
                    tag_vld_q[gi] <= tag_vld_d[gi];
                    tag_id_q[gi]  <= tag_id_d[gi];
                end
            end
        end

        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_vld_q[N_STG-1] &&
                                   (tag_id_q[N_STG-1] == ID_W'(gi));
        end
    endgenerate

    assign rsp_s = add_s;
    assign busy  = |tag_vld_q;

endmodule

// File: tb/tb_add_arb.sv
// Testbench for add_arb: table-driven directed vectors, then randomized
// traffic checked cycle by cycle against a queue-based reference model.
module tb_add_arb;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_s;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_s;
    logic             busy;

    always #5 clk = ~clk;

    add_arb #(.N_REQ(N), .WIDTH(W), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_s(rsp_s), .busy(busy)
    );

    // External registered adder with LAT cycles of latency.
    logic [W-1:0] s_pipe [0:LAT-1];
    always @(posedge clk) begin
        s_pipe[0] <= add_a + add_b;
        for (int i = 1; i < LAT; i++) s_pipe[i] <= s_pipe[i-1];
    end
    assign add_s = s_pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp, input int cyc);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive values for the current cycle.
    logic         drv_rst;
    logic         drv_en;
    logic [N-1:0] drv_valid;
    logic [W-1:0] drv_a [0:N-1];
    logic [W-1:0] drv_b [0:N-1];

    // Reference model: search pointer plus a queue of outstanding results.
    typedef struct {
        int           id;
        logic [W-1:0] sum;
        int           due;
    } pend_t;

    pend_t q[$];
    int    m_ptr = 0;
    int    cyc   = 0;

    function automatic int model_grant(input int ptr, input logic e,
                                       input logic r, input logic [N-1:0] v);
        if (!e || r) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check at negedge, advance model at posedge.
    task automatic step(input logic use_tab, input logic [N-1:0] t_ready,
                        input logic [N-1:0] t_rsp, input logic [W-1:0] t_s,
                        input logic t_busy);
        int           g;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        logic [W-1:0] e_s;
        logic         e_busy;
        pend_t        p;
        rst       = drv_rst;
        en        = drv_en;
        req_valid = drv_valid;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = drv_a[i];
            req_b[i*W +: W] = drv_b[i];
        end
        g       = model_grant(m_ptr, drv_en, drv_rst, drv_valid);
        e_ready = (g >= 0) ? N'(1 << g) : '0;
        e_rsp   = '0;
        e_s     = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_rsp = N'(1 << q[0].id);
            e_s   = q[0].sum;
        end
        e_busy = (q.size() > 0);
        @(negedge clk);
        check("req_ready", W'(req_ready), W'(e_ready), cyc);
        check("rsp_valid", W'(rsp_valid), W'(e_rsp), cyc);
        if (e_rsp != '0) check("rsp_s", rsp_s, e_s, cyc);
        check("busy", W'(busy), W'(e_busy), cyc);
        if (use_tab) begin
            check("tab_ready", W'(req_ready), W'(t_ready), cyc);
            check("tab_rsp_valid", W'(rsp_valid), W'(t_rsp), cyc);
            if (t_rsp != '0) check("tab_rsp_s", rsp_s, t_s, cyc);
            check("tab_busy", W'(busy), W'(t_busy), cyc);
        end
        $display("cycle %0d rst=%b en=%b valid=%b ready=%b rsp_valid=%b rsp_s=%h busy=%b",
                 cyc, drv_rst, drv_en, drv_valid, req_ready, rsp_valid, rsp_s, busy);
        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        @(posedge clk);
        if (drv_rst) begin
            q.delete();
            m_ptr = 0;
        end else if (g >= 0) begin
            p.id  = g;
            p.sum = drv_a[g] + drv_b[g];
            p.due = cyc + 1 + LAT;
            q.push_back(p);
`ifndef ADD_ARB_FIXED_PRIO_EN
            m_ptr = (g + 1) % N;
`endif
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic         en;
        logic [N-1:0] valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] ready;
        logic [N-1:0] rsp;
        logic [W-1:0] s;
        logic         busy;
    } rec_t;

    rec_t tab[$];

    function automatic void add(input logic r, input logic e, input logic [N-1:0] v,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [N-1:0] rd, input logic [N-1:0] rp,
                                input logic [W-1:0] s, input logic bz);
        rec_t t;
        t.rst = r; t.en = e; t.valid = v; t.a = a; t.b = b;
        t.ready = rd; t.rsp = rp; t.s = s; t.busy = bz;
        tab.push_back(t);
    endfunction

    initial begin
        // Reset held, requests present: nothing granted.
        add(1, 1, 4'b1111, 32'h1, 32'h1, 4'b0000, 4'b0000, 32'h0, 0);
        add(1, 0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
`ifndef ADD_ARB_FIXED_PRIO_EN
        // Single transfer from requester 0.
        add(0, 1, 4'b0001, 32'hCFF, 32'h3BB, 4'b0001, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0001, 32'h10BA, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        // en low blocks grants; ptr is 1.
        add(0, 0, 4'b1010, 32'h1, 32'h2, 4'b0000, 4'b0000, 32'h0, 0);
        add(0, 0, 4'b1010, 32'h1, 32'h2, 4'b0000, 4'b0000, 32'h0, 0);
        add(0, 0, 4'b1010, 32'h1, 32'h2, 4'b0000, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b1010, 32'h1, 32'h2, 4'b0010, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b1000, 32'h1, 32'h2, 4'b1000, 4'b0000, 32'h0, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0010, 32'h3, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b1000, 32'h3, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        // All four valid: rotate 0..3.
        add(0, 1, 4'b1111, 32'hFFFF, 32'hFFFF, 4'b0001, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b1110, 32'hFFFF, 32'hFFFF, 4'b0010, 4'b0000, 32'h0, 1);
        add(0, 1, 4'b1100, 32'hFFFF, 32'hFFFF, 4'b0100, 4'b0001, 32'h1FFFE, 1);
        add(0, 1, 4'b1000, 32'hFFFF, 32'hFFFF, 4'b1000, 4'b0010, 32'h1FFFE, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0100, 32'h1FFFE, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b1000, 32'h1FFFE, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        // Carry dropped.
        add(0, 1, 4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0100, 32'hFFFFFFFE, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        // Reset one cycle after a grant to requester 1 (ptr=3 wraps to 1).
        add(0, 1, 4'b0010, 32'h5, 32'h6, 4'b0010, 4'b0000, 32'h0, 0);
        add(1, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
`else
        // Fixed priority: requester 2 starves behind requester 0.
        add(0, 1, 4'b0101, 32'h10, 32'h20, 4'b0001, 4'b0000, 32'h0, 0);
        add(0, 1, 4'b0101, 32'h10, 32'h20, 4'b0001, 4'b0000, 32'h0, 1);
        add(0, 1, 4'b0101, 32'h10, 32'h20, 4'b0001, 4'b0001, 32'h30, 1);
        add(0, 1, 4'b0101, 32'h10, 32'h20, 4'b0001, 4'b0001, 32'h30, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0001, 32'h30, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0001, 32'h30, 1);
        add(0, 1, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0);
`endif

        // Initial reset and reset-state operand check.
        rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        @(posedge clk);
        #1;
        check("add_a_reset", add_a, 32'h0, cyc);
        check("add_b_reset", add_b, 32'h0, cyc);

        foreach (tab[i]) begin
            drv_rst   = tab[i].rst;
            drv_en    = tab[i].en;
            drv_valid = tab[i].valid;
            for (int k = 0; k < N; k++) begin
                drv_a[k] = tab[i].a;
                drv_b[k] = tab[i].b;
            end
            step(1'b1, tab[i].ready, tab[i].rsp, tab[i].s, tab[i].busy);
        end

        // Single requester held continuously: granted every cycle.
        drv_rst = 1'b0; drv_en = 1'b1; drv_valid = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < N; k++) begin
                drv_a[k] = W'(c * 3 + k);
                drv_b[k] = W'(100 + c);
            end
            step(1'b0, '0, '0, '0, 1'b0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drv_rst   = ($urandom_range(0, 59) == 0);
            drv_en    = ($urandom_range(0, 7) != 0);
            drv_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                drv_a[k] = $urandom;
                drv_b[k] = $urandom;
            end
            step(1'b0, '0, '0, '0, 1'b0);
        end

        // Drain.
        drv_rst = 1'b0; drv_en = 1'b1; drv_valid = '0;
        for (int c = 0; c < LAT + 3; c++) step(1'b0, '0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_arb.md
# add_arb

Round-robin arbiter and sequencer that shares the single registered 32-bit adder among `N_REQ` requesters, e.g. FIR tap accumulators. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. It tracks each pair through the adder latency with a tag pipeline and returns each sum to the originating requester with a one-cycle valid pulse.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand and sum width.
- `ADD_LAT`, 1: cycles from `add_a`/`add_b` presented to `add_s` valid; 1..4.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: grant enable; low blocks new grants, in-flight operations still complete.
- `req_valid`  in  N_REQ: requester i has an operand pair.
- `req_ready`  out  N_REQ: one-hot grant; requester i's pair accepted this cycle.
- `req_a`, `req_b`  in  N_REQ*WIDTH: operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `add_a`, `add_b`  out  WIDTH: registered operands to the adder.
- `add_s`  in  WIDTH: adder sum.
- `rsp_valid`  out  N_REQ: one-hot pulse; the sum for requester i is on `rsp_s`.
- `rsp_s`  out  WIDTH: sum returned.
- `busy`  out  1: at least one operation is in flight.

## Operation
- Grant is combinational in cycle T: among requesters with `req_valid` high, pick the first at or after pointer `ptr`, searching upward with wrap-around. Assert that requester's `req_ready`, only when `en`=1 and not `rst`.
- A transfer is `req_valid[i] & req_ready[i]`. On that edge:
  - `add_a`/`add_b` load the granted operands.
  - The tag pipeline stage 0 loads {valid=1, id=i}.
  - `ptr` moves to i+1 mod N_REQ.
- With no transfer, `add_a`/`add_b` hold their value, stage 0 loads valid=0, and `ptr` holds.
- The tag pipeline has ADD_LAT+1 stages and shifts every cycle, regardless of `en`.
- When the last stage is valid with id k:
  - `rsp_valid[k]`=1 for exactly one cycle.
  - `rsp_s`=`add_s` combinationally.
- Arithmetic: sum is modulo 2^WIDTH, carry-out dropped (0xFFFFFFFF+0xFFFFFFFF = 0xFFFFFFFE).
- A requester may hold `req_valid` across cycles; it is re-arbitrated each cycle with no starvation. Each valid requester is granted within N_REQ cycles.
- Responses cannot be backpressured. Requesters must sink `rsp_valid` unconditionally.
- `busy` = OR of valid bits across all tag stages.
- Requester ids index results only; responses emerge in issue order.

## Timing
- Reset values: `req_ready`=0, `add_a`=0, `add_b`=0, `rsp_valid`=0, `rsp_s`=`add_s` (don't care), `busy`=0, `ptr`=0, all tag stages invalid.
- Latency: transfer in cycle T gives `rsp_valid` in cycle T+1+ADD_LAT.
- Throughput: one transfer per cycle, sustained.
- Reset mid-operation: all in-flight tags are discarded. No `rsp_valid` appears for pre-reset transfers, even though the adder may still emit sums.
- `en` falling in cycle T: no grant in T. In-flight responses still appear on schedule.
- `en` rising: grants resume in the same cycle, from the held `ptr`.
- All requesters valid at once: grants rotate ptr, ptr+1, …, one per cycle.
- Single requester valid continuously: granted every cycle; `ptr` follows it.
- `req_valid` dropped without a grant is allowed. No state is kept for that requester.

## Configuration
- `ADD_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest index always wins.
  - `ptr` is removed (constant 0).
  - Starvation of high indices is permitted.
- Not defined: round-robin as above (default build).

## Test plan
- After reset with N_REQ=4, ADD_LAT=1: requester 0 sends 0xCFF+0x3BB, granted cycle T -> `rsp_valid`=4'b0001 and `rsp_s`=0x10BA in cycle T+2; `busy` high for cycles T+1..T+2.
- Requesters 0..3 all valid from cycle T, each with a+b = 0xFFFF+0xFFFF -> grants 0,1,2,3 in T..T+3; responses 4'b0001, 4'b0010, 4'b0100, 4'b1000 in T+2..T+5; each `rsp_s`=0x1FFFE.
- Requester 2 sends 0xFFFFFFFF+0xFFFFFFFF -> `rsp_valid[2]` with `rsp_s`=0xFFFFFFFE (carry dropped).
- `en`=0 with requesters 1 and 3 valid for 3 cycles -> `req_ready`=0 throughout. Raise `en` -> requester 1 granted first (ptr=1 after a prior grant to 0), then 3.
- Assert `rst` one cycle after a grant to requester 1 -> no `rsp_valid` in the following 4 cycles; `busy`=0 the cycle after reset.
- With `ADD_ARB_FIXED_PRIO_EN`, requesters 0 and 2 held valid for 4 cycles -> `req_ready` = 4'b0001 every cycle; requester 2 never granted.
